// File: rtl/lsu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : lsu_ctrl_pkg
// Purpose  : rv32 load/store funct3 encodings, access-size decode, LSU FSM states.
// Revision : 1.0
// ============================================================================
package lsu_ctrl_pkg;

    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;
    localparam logic [2:0] LSU_SB  = 3'b000;
    localparam logic [2:0] LSU_SH  = 3'b001;
    localparam logic [2:0] LSU_SW  = 3'b010;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Reserved encodings (011/110/111) fall through to a word access.
    function automatic lsu_size_e lsu_size(input logic [2:0] funct3);
        lsu_size_e sz;
        case (funct3)
            LSU_LB, LSU_LBU: sz = SZ_BYTE;
            LSU_LH, LSU_LHU: sz = SZ_HALF;
            default:         sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : byte-lane generation for stores and lane extract/extend for loads.
// Revision : 1.0
// ============================================================================
module lsu_align
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      st_op_i,
    input  logic [1:0]      st_alo_i,
    input  logic [XLEN-1:0] st_data_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    input  logic [2:0]      ld_op_i,
    input  logic [1:0]      ld_alo_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] ldata_o
);

    logic [XLEN-1:0] w_shifted;

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = '0;
        case (lsu_size(st_op_i))
            SZ_BYTE: begin
                be_o    = 4'b0001 << st_alo_i;
                wdata_o = {4{st_data_i[7:0]}};
            end
            SZ_HALF: begin
                be_o    = 4'b0011 << st_alo_i;
                wdata_o = {2{st_data_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = st_data_i;
            end
        endcase
    end

    // funct3 bit 2 selects zero extension.
    always_comb begin
        w_shifted = rdata_i >> {ld_alo_i, 3'b000};
        ldata_o   = w_shifted;
        case (lsu_size(ld_op_i))
            SZ_BYTE: ldata_o = {{24{w_shifted[7] & ~ld_op_i[2]}}, w_shifted[7:0]};
            SZ_HALF: ldata_o = {{16{w_shifted[15] & ~ld_op_i[2]}}, w_shifted[15:0]};
            default: ldata_o = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Purpose  : single-outstanding load/store controller on a req/gnt/rvalid bus.
//            Macro LSU_MISALIGN_TRAP_EN: misaligned accesses trap instead of aligning.
// Revision : 1.0
// ============================================================================
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            mem_read_ex,
    input  logic            mem_write_sel_ex,
    input  logic [2:0]      lsu_op_ex,
    input  logic [XLEN-1:0] addr_ex,
    input  logic [XLEN-1:0] store_data_ex,
    output logic            lsu_stall_o,
    output logic            load_valid_o,
    output logic [XLEN-1:0] load_data_o,
    output logic            misalign_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i
);

    lsu_state_e      state_q, state_d;
    logic [2:0]      op_q;
    logic            we_q;
    logic [1:0]      alo_q;
    logic [3:0]      be_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-3:0] waddr_q;
    logic [XLEN-1:0] ldata_q;

    lsu_size_e       w_size;
    logic            w_acc;
    logic            w_misal;
    logic            w_start;
    logic            w_ld_cap;
    logic            w_in_req;
    logic [1:0]      w_alo;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_ldata;

    assign w_size = lsu_size(lsu_op_ex);
    assign w_acc  = mem_read_ex | mem_write_sel_ex;

    // Low address bits are forced aligned; in trap builds they are already aligned here.
    always_comb begin
        w_alo = addr_ex[1:0];
        case (w_size)
            SZ_HALF: w_alo = {addr_ex[1], 1'b0};
            SZ_WORD: w_alo = 2'b00;
            default: w_alo = addr_ex[1:0];
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;

    assign w_misal = ((w_size == SZ_HALF) && addr_ex[0]) ||
                     ((w_size == SZ_WORD) && (addr_ex[1:0] != 2'b00));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= (state_q == ST_IDLE) && w_acc && w_misal;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign w_misal    = 1'b0;
    assign misalign_o = 1'b0;
`endif

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .st_op_i   (lsu_op_ex),
        .st_alo_i  (w_alo),
        .st_data_i (store_data_ex),
        .be_o      (w_be),
        .wdata_o   (w_wdata),
        .ld_op_i   (op_q),
        .ld_alo_i  (alo_q),
        .rdata_i   (dmem_rdata_i),
        .ldata_o   (w_ldata)
    );

    always_comb begin
        state_d  = state_q;
        w_start  = 1'b0;
        w_ld_cap = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_acc && !w_misal) begin
                    w_start = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (dmem_gnt_i) begin
                    if (we_q) begin
                        state_d = ST_DONE;
                    end else if (dmem_rvalid_i) begin
                        w_ld_cap = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (dmem_rvalid_i) begin
                    w_ld_cap = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            op_q    <= 3'b000;
            we_q    <= 1'b0;
            alo_q   <= 2'b00;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            waddr_q <= '0;
            ldata_q <= '0;
        end else begin
            state_q <= state_d;
            if (w_start) begin
                op_q    <= lsu_op_ex;
                we_q    <= mem_write_sel_ex;
                alo_q   <= w_alo;
                be_q    <= w_be;
                wdata_q <= w_wdata;
                waddr_q <= addr_ex[XLEN-1:2];
            end
            if (w_ld_cap) begin
                ldata_q <= w_ldata;
            end
        end
    end

    // Bus outputs come straight from the capture registers, so they hold until grant.
    assign w_in_req     = (state_q == ST_REQ);
    assign dmem_req_o   = w_in_req;
    assign dmem_we_o    = w_in_req & we_q;
    assign dmem_addr_o  = w_in_req ? {waddr_q, 2'b00} : '0;
    assign dmem_be_o    = w_in_req ? be_q : 4'b0000;
    assign dmem_wdata_o = w_in_req ? wdata_q : '0;

    assign lsu_stall_o  = ((state_q == ST_IDLE) && w_acc && !w_misal) ||
                          w_in_req || (state_q == ST_RESP);
    assign load_valid_o = (state_q == ST_DONE) && !we_q;
    assign load_data_o  = ldata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_ctrl
// Purpose  : self-checking bench for lsu_ctrl against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_lsu_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        mem_read_ex = 1'b0;
    logic        mem_write_sel_ex = 1'b0;
    logic [2:0]  lsu_op_ex = 3'b000;
    logic [31:0] addr_ex = '0;
    logic [31:0] store_data_ex = '0;
    logic        lsu_stall_o;
    logic        load_valid_o;
    logic [31:0] load_data_o;
    logic        misalign_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i = 1'b0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;

    int total = 0;
    int bad   = 0;

    lsu_ctrl #(.XLEN(32)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .mem_read_ex      (mem_read_ex),
        .mem_write_sel_ex (mem_write_sel_ex),
        .lsu_op_ex        (lsu_op_ex),
        .addr_ex          (addr_ex),
        .store_data_ex    (store_data_ex),
        .lsu_stall_o      (lsu_stall_o),
        .load_valid_o     (load_valid_o),
        .load_data_o      (load_data_o),
        .misalign_o       (misalign_o),
        .dmem_req_o       (dmem_req_o),
        .dmem_we_o        (dmem_we_o),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_be_o        (dmem_be_o),
        .dmem_wdata_o     (dmem_wdata_o),
        .dmem_gnt_i       (dmem_gnt_i),
        .dmem_rvalid_i    (dmem_rvalid_i),
        .dmem_rdata_i     (dmem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] op);
        case (op)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // One whole access: IDLE cycle, REQ for gw+1 cycles, RESP for rw cycles (loads), DONE.
    task automatic access(input bit we, input bit rd, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input int gw, input int rw, input logic [31:0] rdata,
                          input bit pin, input logic [3:0] pbe,
                          input logic [31:0] pwd, input logic [31:0] pld);
        int n;
        int a;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] eld;
        logic [31:0] sh;
        logic [31:0] mask;
        n = nbytes(op);
        a = int'(addr[1:0]);
        a = a - (a % n);
        for (int k = 0; k < 4; k++) begin
            ebe[k] = (k >= a) && (k < a + n);
            ewd[8*k +: 8] = sd[8*(k % n) +: 8];
        end
        sh   = rdata >> (8 * a);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        eld  = sh & mask;
        if (!op[2] && n < 4 && sh[8*n-1]) eld = eld | ~mask;

        @(negedge clk_i);
        mem_read_ex = rd; mem_write_sel_ex = we; lsu_op_ex = op;
        addr_ex = addr; store_data_ex = sd;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        #1;
        chk("idle_stall", 32'(lsu_stall_o), 32'd1);
        chk("idle_req", 32'(dmem_req_o), 32'd0);
        chk("idle_lvalid", 32'(load_valid_o), 32'd0);
        chk("idle_misalign", 32'(misalign_o), 32'd0);

        for (int k = 0; k <= gw; k++) begin
            @(negedge clk_i);
            dmem_gnt_i    = (k == gw);
            dmem_rvalid_i = (k == gw) && !we && (rw == 0);
            dmem_rdata_i  = dmem_rvalid_i ? rdata : $urandom;
            #1;
            chk("req_req", 32'(dmem_req_o), 32'd1);
            chk("req_stall", 32'(lsu_stall_o), 32'd1);
            chk("req_we", 32'(dmem_we_o), 32'(we));
            chk("req_addr", dmem_addr_o, {addr[31:2], 2'b00});
            chk("req_be", 32'(dmem_be_o), 32'(ebe));
            if (we) chk("req_wdata", dmem_wdata_o, ewd);
            if (pin && k == 0) begin
                chk("pin_be", 32'(dmem_be_o), 32'(pbe));
                if (we) chk("pin_wdata", dmem_wdata_o, pwd);
            end
        end

        if (!we) begin
            for (int j = 1; j <= rw; j++) begin
                @(negedge clk_i);
                dmem_gnt_i    = 1'b0;
                dmem_rvalid_i = (j == rw);
                dmem_rdata_i  = dmem_rvalid_i ? rdata : $urandom;
                #1;
                chk("resp_req", 32'(dmem_req_o), 32'd0);
                chk("resp_stall", 32'(lsu_stall_o), 32'd1);
                chk("resp_lvalid", 32'(load_valid_o), 32'd0);
            end
        end

        // DONE: a stray rvalid here must not matter.
        @(negedge clk_i);
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'($urandom_range(0, 1));
        dmem_rdata_i  = $urandom;
        #1;
        chk("done_stall", 32'(lsu_stall_o), 32'd0);
        chk("done_req", 32'(dmem_req_o), 32'd0);
        chk("done_lvalid", 32'(load_valid_o), 32'(!we));
        if (!we) begin
            chk("done_ldata", load_data_o, eld);
            if (pin) chk("pin_ldata", load_data_o, pld);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk_i);
        mem_read_ex = 1'b0; mem_write_sel_ex = 1'b0;
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'($urandom_range(0, 1));
        dmem_rdata_i = $urandom;
        #1;
        chk("gap_stall", 32'(lsu_stall_o), 32'd0);
        chk("gap_req", 32'(dmem_req_o), 32'd0);
        chk("gap_lvalid", 32'(load_valid_o), 32'd0);
        chk("gap_misalign", 32'(misalign_o), 32'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] ad;
        bit          we;
        bit          rd;
        int          n;

        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_stall", 32'(lsu_stall_o), 32'd0);
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_we", 32'(dmem_we_o), 32'd0);
        chk("rst_addr", dmem_addr_o, 32'd0);
        chk("rst_be", 32'(dmem_be_o), 32'd0);
        chk("rst_wdata", dmem_wdata_o, 32'd0);
        chk("rst_lvalid", 32'(load_valid_o), 32'd0);
        chk("rst_ldata", load_data_o, 32'd0);
        chk("rst_misalign", 32'(misalign_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        idle_cycle();

        // Directed accesses with hand-computed expectations.
        access(1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 2, 1, 32'hDEADBEEF,
               1'b1, 4'b1111, 32'h0, 32'hDEADBEEF);
        idle_cycle();
        access(1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80123456,
               1'b1, 4'b1000, 32'h0, 32'hFFFFFF80);
        access(1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 1, 2, 32'h80123456,
               1'b1, 4'b1000, 32'h0, 32'h00000080);
        access(1'b1, 1'b0, 3'b001, 32'h202, 32'h1234ABCD, 0, 0, 32'h0,
               1'b1, 4'b1100, 32'hABCDABCD, 32'h0);
        access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0, 1, 0, 32'h8001_7FFF,
               1'b1, 4'b1100, 32'h0, 32'hFFFF8001);
        access(1'b1, 1'b1, 3'b000, 32'h401, 32'h000000A5, 0, 0, 32'h0,
               1'b1, 4'b0010, 32'hA5A5A5A5, 32'h0);
        idle_cycle();

        // Reset while waiting for the response.
        @(negedge clk_i);
        mem_read_ex = 1'b1; lsu_op_ex = 3'b010; addr_ex = 32'h300;
        @(negedge clk_i);
        dmem_gnt_i = 1'b1;
        @(negedge clk_i);
        dmem_gnt_i = 1'b0;
        #1;
        chk("mid_resp_stall", 32'(lsu_stall_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1; mem_read_ex = 1'b0;
        #1;
        chk("mid_rst_req", 32'(dmem_req_o), 32'd0);
        chk("mid_rst_stall", 32'(lsu_stall_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h12345678;
        #1;
        chk("post_rst_stall", 32'(lsu_stall_o), 32'd0);
        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        #1;
        chk("post_rst_lvalid", 32'(load_valid_o), 32'd0);
        chk("post_rst_req", 32'(dmem_req_o), 32'd0);
        access(1'b0, 1'b1, 3'b010, 32'h500, 32'h0, 0, 1, 32'h0BADF00D,
               1'b1, 4'b1111, 32'h0, 32'h0BADF00D);
        idle_cycle();

`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge clk_i);
        mem_read_ex = 1'b1; lsu_op_ex = 3'b010; addr_ex = 32'h101;
        #1;
        chk("trap_stall", 32'(lsu_stall_o), 32'd0);
        chk("trap_req0", 32'(dmem_req_o), 32'd0);
        @(negedge clk_i);
        mem_read_ex = 1'b0;
        #1;
        chk("trap_misalign", 32'(misalign_o), 32'd1);
        chk("trap_req1", 32'(dmem_req_o), 32'd0);
        idle_cycle();
`else
        access(1'b0, 1'b1, 3'b010, 32'h101, 32'h0, 0, 1, 32'hCAFEF00D,
               1'b1, 4'b1111, 32'h0, 32'hCAFEF00D);
        idle_cycle();
`endif

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            we = ($urandom_range(0, 2) == 0);
            rd = we ? 1'($urandom_range(0, 1)) : 1'b1;
            op = 3'($urandom_range(0, 7));
            ad = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
            n  = nbytes(op);
            ad[1:0] = 2'(int'(ad[1:0]) - (int'(ad[1:0]) % n));
`else
            n  = 0;
`endif
            access(we, rd, op, ad + 32'(n), $urandom, $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom, 1'b0, 4'b0, 32'h0, 32'h0);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
